asciidec_to_binary: RTL and testbench
=====================================

// Module: asciidec_to_binary
// PURPOSE
//  Serial parser for ASCII decimal numbers: one 7-bit character per handshake,
//  accumulates digits, presents a WIDTH-bit unsigned binary value on delimiter.
//  Inverse of the binary-to-ASCII display formatter; sits between the keyboard/
//  UART character stream and timer/counter preset registers.
// PARAMETERS
//  WIDTH       16  result width in bits (max value 2**WIDTH-1)
//  MAX_DIGITS  7   max digit characters per number (leading zeros count)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  in_char       in   7      ASCII character
//  in_valid      in   1      in_char valid
//  in_ready      out  1      parser accepts in_char this cycle
//  out_val       out  WIDTH  parsed value
//  out_valid     out  1      result available
//  out_ready     in   1      consumer takes result
//  out_overflow  out  1      value exceeded 2**WIDTH-1; out_val saturated
//  out_error     out  1      bad character or too many digits; out_val = 0
//  busy          out  1      at least one digit accepted, no result yet
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, acc=0, cnt=0, all outputs 0;
//   partial number discarded.
//  Char accepted when in_valid & in_ready. Digits 0x30..0x39; delimiters
//   0x20 (space), 0x0D (CR); all other codes invalid.
//  in_ready = (state != HOLD); depends on state only, never on in_valid.
//  IDLE: digit -> acc=d, cnt=1, go ACCUM. Delimiter -> ignored (leading
//   blanks skipped). Invalid -> HOLD, error=1.
//  ACCUM (busy=1): digit -> cnt==MAX_DIGITS: HOLD, error=1; else cnt+1,
//   acc_next = acc*10 + d computed WIDTH+4 bits wide (shift-add: acc<<3 +
//   acc<<1 + d); if acc_next > 2**WIDTH-1 set sticky ovf, acc = all ones.
//   Delimiter -> HOLD, out_val=acc, out_overflow=ovf. Invalid -> HOLD, error=1.
//  HOLD: out_valid=1; out_val/out_overflow/out_error stable until taken.
//   out_ready=1 -> next cycle IDLE, out_valid=0, acc/cnt/ovf/error cleared.
//  Error result: out_val=0, out_overflow=0, out_error=1 (error dominates ovf).
//  Latency: out_valid rises the cycle after the delimiter handshake; back-to-
//   back numbers cost 1 dead cycle (HOLD->IDLE) minimum.
//  in_valid & out_ready same cycle in HOLD: result taken, char not accepted
//   (in_ready=0); char must be re-offered.
//  One char per cycle; no backspace/sign support.
// TESTING
//  "1234\r" back-to-back -> out_val=0x04D2, ovf=0, err=0, out_valid 1 cycle
//   after CR.
//  "65535 " -> 0xFFFF ovf=0; "65536 " -> 0xFFFF ovf=1; "99999999" -> err=1
//   (8th digit, MAX_DIGITS=7).
//  "   42 " -> leading spaces ignored, out_val=42, busy=1 only after '4'.
//  "12A" -> HOLD on 'A', out_val=0, err=1; then "7 " -> 7, err cleared.
//  After "5 ", hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0,
//   out_val=5 stable; out_ready=1 -> IDLE next cycle, pending char then taken.
//  "12" then rst_n low mid-cycle -> outputs 0 immediately; then "5 " -> 5.

Source files
------------

// File: rtl/asciidec_to_binary.sv
// Serial ASCII-decimal to unsigned binary parser; result valid the cycle after the delimiter.
// The result is held until out_ready. No characters are accepted while a result is pending.
module asciidec_to_binary #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       in_char,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_overflow,
  output logic             out_error,
  output logic             busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             err, err_nxt;

  logic             accept;
  logic             is_digit;
  logic             is_delim;
  logic [3:0]       digit;
  logic [WIDTH+3:0] acc_wide;
  logic [WIDTH+3:0] prod;
  logic             prod_sat;

  assign is_digit = (in_char >= 7'h30) && (in_char <= 7'h39);
  assign is_delim = (in_char == 7'h20) || (in_char == 7'h0D);
  assign digit    = in_char[3:0];
  assign accept   = in_valid & in_ready;

  // acc*10 + d as (acc<<3)+(acc<<1)+d, four extra bits so nothing is lost before the saturation test
  assign acc_wide = {4'b0000, acc};
  assign prod     = (acc_wide << 3) + (acc_wide << 1) + {{WIDTH{1'b0}}, digit};
  assign prod_sat = |prod[WIDTH+3:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_nxt   = {{(WIDTH-4){1'b0}}, digit};
            cnt_nxt   = CW'(1);
            state_nxt = ACCUM;
          end else if (!is_delim) begin
            acc_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt == CW'(MAX_DIGITS)) begin
              acc_nxt   = '0;
              ovf_nxt   = 1'b0;
              err_nxt   = 1'b1;
              state_nxt = HOLD;
            end else begin
              cnt_nxt = cnt + CW'(1);
              if (prod_sat) begin
                acc_nxt = '1;
                ovf_nxt = 1'b1;
              end else begin
                acc_nxt = prod[WIDTH-1:0];
              end
            end
          end else if (is_delim) begin
            state_nxt = HOLD;
          end else begin
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready     = (state != HOLD);
  assign out_valid    = (state == HOLD);
  assign busy         = (state == ACCUM);
  assign out_val      = (out_valid && !err) ? acc : '0;
  assign out_overflow = out_valid & ovf & ~err;
  assign out_error    = out_valid & err;

endmodule

// File: tb/tb_asciidec_to_binary.sv
// Directed bench for asciidec_to_binary: table of character strings with expected results plus stall/reset sequences.
module tb_asciidec_to_binary;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_val;
  logic        out_valid;
  logic        out_ready;
  logic        out_overflow;
  logic        out_error;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  asciidec_to_binary #(.WIDTH(16), .MAX_DIGITS(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_char      (in_char),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_val      (out_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_overflow (out_overflow),
    .out_error    (out_error),
    .busy         (busy)
  );

  typedef struct {
    logic [87:0] chars;
    int          len;
    logic [15:0] val;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge on which the char was taken.
  task automatic send_char(input logic [7:0] c);
    int waited;
    waited   = 0;
    in_char  = c[6:0];
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [15:0] val,
                               input logic ovf, input logic err);
    @(negedge clk);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_val"}, {16'b0, out_val}, {16'b0, val});
    check({name, "_ovf"}, {31'b0, out_overflow}, {31'b0, ovf});
    check({name, "_err"}, {31'b0, out_error}, {31'b0, err});
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_inrdy"}, {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_taken"}, {31'b0, out_valid}, 32'd0);
    check({name, "_clr_err"}, {31'b0, out_error}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"1234\r",   5, 16'h04D2, 1'b0, 1'b0};
    vecs[1]  = '{"65535 ",   6, 16'hFFFF, 1'b0, 1'b0};
    vecs[2]  = '{"65536 ",   6, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{"99999999", 8, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{"12A",      3, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{"7 ",       2, 16'h0007, 1'b0, 1'b0};
    vecs[6]  = '{"0065535\r",8, 16'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{"6553500 ", 8, 16'hFFFF, 1'b1, 1'b0};
    vecs[8]  = '{"0 ",       2, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{"/",        1, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{"1:",       2, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{"00000001", 8, 16'h0000, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_char   = 7'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_val", {16'b0, out_val}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, out_error}, 32'd0);
    check("rst_ovf", {31'b0, out_overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < vecs[i].len; k++) begin
        send_char(vecs[i].chars[(vecs[i].len - 1 - k) * 8 +: 8]);
      end
      expect_result($sformatf("vec%0d", i), vecs[i].val, vecs[i].ovf, vecs[i].err);
    end

    // Leading blanks are skipped; busy rises only with the first digit.
    for (int k = 0; k < 3; k++) begin
      send_char(8'h20);
      check($sformatf("lead_sp%0d_busy", k), {31'b0, busy}, 32'd0);
    end
    send_char("4");
    check("lead_4_busy", {31'b0, busy}, 32'd1);
    send_char("2");
    send_char(" ");
    expect_result("lead42", 16'd42, 1'b0, 1'b0);

    // Result stalled for 10 cycles with a character pending.
    send_char("5");
    send_char(" ");
    in_char  = 7'h33;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_inrdy", k), {31'b0, in_ready}, 32'd0);
      check($sformatf("stall%0d_val", k), {16'b0, out_val}, 32'd5);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall_idle_busy", {31'b0, busy}, 32'd0);
    check("stall_idle_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("stall_pending_taken", {31'b0, busy}, 32'd1);
    send_char(" ");
    expect_result("pending3", 16'd3, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a number.
    send_char("1");
    send_char("2");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_val", {16'b0, out_val}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_char("5");
    send_char(" ");
    expect_result("post_rst5", 16'd5, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
